rx_frame_mem: RTL and testbench

// - Receive-side counterpart of the 4-channel Y-plane transmitter: accepts four 12-bit pixel streams with explicit word addresses.
// - Writes each stream into its own bank (pixel p lives in bank p[1:0], word p>>2) and tracks per-channel frame completion.
// - Raises a frame-done pulse once all enabled channels finish a frame.
// - Replays the stored frame to the HDMI path as 24-bit grey pixels, paced by an internal pixel strobe.

---
 rtl/rx_pkg.sv | 21 ++
 rtl/rx_chan_tracker.sv | 79 +++++++
 rtl/rx_frame_mem.sv | 158 +++++++++++++++
 tb/tb_rx_frame_mem.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types, default sizes and the grey-expand helper for the rx_frame_mem receive buffer.
package rx_pkg;

  localparam int DEPTH_DEF = 38400;
  localparam int AW_DEF    = 16;
  localparam int DIV_DEF   = 5;
  localparam int NCH       = 4;
  localparam int DW        = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } chan_state_t;

  // 12-bit luma to 24-bit grey: each nibble padded with 4'hf on the low side.
  function automatic logic [23:0] grey_expand(input logic [DW-1:0] y);
    return {y[11:8], 4'hf, y[7:4], 4'hf, y[3:0], 4'hf};
  endfunction

endpackage

// File: rtl/rx_chan_tracker.sv
// Per-channel frame tracker: write qualification, completion FSM and optional address-sequence errors.
// Optional feature macro: RX_ERR_CNT_EN adds the err_inc output.
//
// state  | meaning
// IDLE   | channel not in a frame (RecEn low)
// ACTIVE | frame in progress, last word not yet written
// DONE   | last word written; stays here until RecEn drops
module rx_chan_tracker
  import rx_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rec_en,
  input  logic          rec_valid,
  input  logic [AW-1:0] rec_add,
  output logic          wr_en,
  output logic          done
`ifdef RX_ERR_CNT_EN
  ,
  output logic          err_inc
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  chan_state_t state_q, state_d;
  logic        in_range;
  logic        last_wr;

  assign in_range = (rec_add <= LAST_ADDR);
  assign wr_en    = rec_valid & rec_en & in_range;
  assign last_wr  = wr_en & (rec_add == LAST_ADDR);
  assign done     = (state_q == DONE);

  // Dropping rec_en wins over completion in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rec_en) state_d = last_wr ? DONE : ACTIVE;
      ACTIVE:  if (!rec_en) state_d = IDLE;
               else if (last_wr) state_d = DONE;
      DONE:    if (!rec_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef RX_ERR_CNT_EN
  logic [AW-1:0] exp_q, exp_d, exp_cur;

  // A channel coming out of IDLE expects word 0, even if it writes in that same cycle.
  always_comb begin
    exp_cur = (state_q == IDLE) ? '0 : exp_q;
    exp_d   = exp_cur;
    err_inc = 1'b0;
    if (rec_valid && rec_en) begin
      if (in_range) begin
        err_inc = (rec_add != exp_cur);
        exp_d   = rec_add + 1'b1;
      end else begin
        err_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) exp_q <= '0;
    else     exp_q <= exp_d;
  end
`endif

endmodule

// File: rtl/rx_frame_mem.sv
// Four-bank Y-plane receive buffer with per-channel frame tracking and paced grey readout to HDMI.
// Optional feature macro: RX_ERR_CNT_EN adds the saturating ErrCnt output.
module rx_frame_mem
  import rx_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DIV   = DIV_DEF
) (
  input  logic                Cclk,
  input  logic                rst,
  input  logic [NCH-1:0]      RecEn,
  input  logic [NCH-1:0]      RecValid,
  input  logic [NCH*DW-1:0]   RecData,
  input  logic [NCH*AW-1:0]   RecAdd,
  input  logic                RecFrameSync,
  output logic                FrameDone,
  output logic                FrameParity,
  output logic [NCH-1:0]      ChanDone,
  output logic                PixelCe,
  input  logic                HVsync,
  input  logic                HMemRead,
  output logic [23:0]         HDMIdata
`ifdef RX_ERR_CNT_EN
  ,
  output logic [15:0]         ErrCnt
`endif
);

  localparam int              PW       = AW + 2;
  localparam int              DCW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PIX_LAST = PW'(NCH * DEPTH - 1);
  localparam logic [DCW-1:0]  DIV_LAST = DCW'(DIV - 1);

  logic [NCH-1:0]    wr_en;
  logic [NCH-1:0]    chan_done;
  logic [NCH*DW-1:0] bank_rd;

  logic [DCW-1:0] div_q, div_d;
  logic           pixel_ce_q, pixel_ce_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [1:0]     rd_sel_q, rd_sel_d;
  logic           rd_vld_q, rd_vld_d;
  logic           rd_req_q, rd_req_d;
  logic [23:0]    hdmi_q, hdmi_d;
  logic           all_ok;
  logic           all_ok_q, all_ok_d;
  logic           frame_done_q, frame_done_d;
  logic           parity_q, parity_d;

`ifdef RX_ERR_CNT_EN
  logic [NCH-1:0] err_inc;
  logic [2:0]     err_sum;
  logic [16:0]    err_acc;
  logic [15:0]    err_cnt_q, err_cnt_d;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q;

    rx_chan_tracker #(
      .DEPTH(DEPTH),
      .AW   (AW)
    ) u_trk (
      .clk      (Cclk),
      .rst      (rst),
      .rec_en   (RecEn[i]),
      .rec_valid(RecValid[i]),
      .rec_add  (RecAdd[i*AW +: AW]),
      .wr_en    (wr_en[i]),
      .done     (chan_done[i])
`ifdef RX_ERR_CNT_EN
      ,
      .err_inc  (err_inc[i])
`endif
    );

    // Read-first bank: a same-cycle write to the read word is not visible until the next read.
    always_ff @(posedge Cclk) begin
      if (wr_en[i]) mem[RecAdd[i*AW +: AW]] <= RecData[i*DW +: DW];
      rd_q <= mem[ptr_q[PW-1:2]];
    end

    assign bank_rd[i*DW +: DW] = rd_q;
  end

  always_comb begin
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pixel_ce_d = (div_d == '0);

    ptr_d = ptr_q;
    if (!HVsync)                      ptr_d = '0;
    else if (pixel_ce_q && HMemRead)  ptr_d = (ptr_q == PIX_LAST) ? '0 : ptr_q + 1'b1;

    rd_sel_d = ptr_q[1:0];
    rd_vld_d = pixel_ce_q;
    rd_req_d = HMemRead;
    hdmi_d   = hdmi_q;
    if (rd_vld_q) hdmi_d = rd_req_q ? grey_expand(bank_rd[rd_sel_q*DW +: DW]) : '0;

    // Disabled channels count as finished; an all-disabled bus never completes a frame.
    all_ok       = (|RecEn) && (&(chan_done | ~RecEn));
    all_ok_d     = all_ok;
    frame_done_d = all_ok && !all_ok_q;
    parity_d     = frame_done_d ? RecFrameSync : parity_q;
  end

`ifdef RX_ERR_CNT_EN
  always_comb begin
    err_sum   = {2'b00, err_inc[0]} + {2'b00, err_inc[1]} + {2'b00, err_inc[2]} + {2'b00, err_inc[3]};
    err_acc   = {1'b0, err_cnt_q} + {14'd0, err_sum};
    err_cnt_d = err_acc[16] ? 16'hffff : err_acc[15:0];
  end
`endif

  always_ff @(posedge Cclk) begin
    if (rst) begin
      div_q        <= '0;
      pixel_ce_q   <= 1'b0;
      ptr_q        <= '0;
      rd_sel_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      hdmi_q       <= '0;
      all_ok_q     <= 1'b0;
      frame_done_q <= 1'b0;
      parity_q     <= 1'b0;
`ifdef RX_ERR_CNT_EN
      err_cnt_q    <= '0;
`endif
    end else begin
      div_q        <= div_d;
      pixel_ce_q   <= pixel_ce_d;
      ptr_q        <= ptr_d;
      rd_sel_q     <= rd_sel_d;
      rd_vld_q     <= rd_vld_d;
      rd_req_q     <= rd_req_d;
      hdmi_q       <= hdmi_d;
      all_ok_q     <= all_ok_d;
      frame_done_q <= frame_done_d;
      parity_q     <= parity_d;
`ifdef RX_ERR_CNT_EN
      err_cnt_q    <= err_cnt_d;
`endif
    end
  end

  assign FrameDone   = frame_done_q;
  assign FrameParity = parity_q;
  assign ChanDone    = chan_done;
  assign PixelCe     = pixel_ce_q;
  assign HDMIdata    = hdmi_q;
`ifdef RX_ERR_CNT_EN
  assign ErrCnt      = err_cnt_q;
`endif

endmodule

// File: tb/tb_rx_frame_mem.sv
// Self-checking bench for rx_frame_mem: frame-level reference model plus directed vectors and random traffic.
module tb_rx_frame_mem;

  localparam int DEPTH = 38400;
  localparam int NPIX  = 4 * DEPTH;
  localparam int DIV   = 5;

  logic        Cclk = 1'b0;
  logic        rst;
  logic [3:0]  RecEn, RecValid;
  logic [47:0] RecData;
  logic [63:0] RecAdd;
  logic        RecFrameSync, HVsync, HMemRead;
  logic        FrameDone, FrameParity, PixelCe;
  logic [3:0]  ChanDone;
  logic [23:0] HDMIdata;
`ifdef RX_ERR_CNT_EN
  logic [15:0] ErrCnt;
`endif

  rx_frame_mem dut (
    .Cclk        (Cclk),
    .rst         (rst),
    .RecEn       (RecEn),
    .RecValid    (RecValid),
    .RecData     (RecData),
    .RecAdd      (RecAdd),
    .RecFrameSync(RecFrameSync),
    .FrameDone   (FrameDone),
    .FrameParity (FrameParity),
    .ChanDone    (ChanDone),
    .PixelCe     (PixelCe),
    .HVsync      (HVsync),
    .HMemRead    (HMemRead),
    .HDMIdata    (HDMIdata)
`ifdef RX_ERR_CNT_EN
    ,
    .ErrCnt      (ErrCnt)
`endif
  );

  always #5 Cclk = ~Cclk;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_count = 0;
  bit chk_en = 1'b0;

  // Reference model: frame memory indexed by pixel number, plus frame-level bookkeeping.
  logic [11:0] ref_mem [NPIX];
  logic [3:0]  m_done;
  logic        m_fd, m_par, m_ok_prev, m_ce, m_sched;
  logic [23:0] m_hdmi, m_sched_val;
  int          m_ptr, m_cyc;
  int          m_err;
  int          m_exp [4];
  bit          m_act [4];

  typedef struct {
    int          ch;
    int          addr;
    logic [11:0] data;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl [5];

  function automatic logic [23:0] exp_grey(input logic [11:0] y);
    logic [23:0] r;
    r = '0;
    for (int n = 2; n >= 0; n--)
      r = (r << 8) | (24'((y >> (4 * n)) & 12'hf) << 4) | 24'hf;
    return r;
  endfunction

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic all_ok;
    if (rst) begin
      m_done = '0; m_fd = 0; m_par = 0; m_ok_prev = 0; m_ce = 0; m_sched = 0;
      m_hdmi = '0; m_ptr = 0; m_cyc = 0; m_err = 0;
      for (int i = 0; i < 4; i++) begin m_exp[i] = 0; m_act[i] = 0; end
      return;
    end
    if (m_sched) begin m_hdmi = m_sched_val; m_sched = 0; end
    if (m_ce) begin
      m_sched     = 1;
      m_sched_val = HMemRead ? exp_grey(ref_mem[m_ptr]) : 24'h0;
    end
    if (!HVsync) m_ptr = 0;
    else if (m_ce && HMemRead) m_ptr = (m_ptr + 1) % NPIX;
    all_ok = |RecEn;
    for (int i = 0; i < 4; i++) if (RecEn[i] && !m_done[i]) all_ok = 0;
    m_fd = all_ok && !m_ok_prev;
    m_ok_prev = all_ok;
    if (m_fd) m_par = RecFrameSync;
    for (int i = 0; i < 4; i++) begin
      int a, cur;
      a = int'(RecAdd[i*16 +: 16]);
      if (!RecEn[i]) begin
        m_done[i] = 0;
        m_act[i]  = 0;
      end else begin
        cur = m_act[i] ? m_exp[i] : 0;
        m_exp[i] = cur;
        if (RecValid[i]) begin
          if (a < DEPTH) begin
            ref_mem[a * 4 + i] = RecData[i*12 +: 12];
            if (a == DEPTH - 1) m_done[i] = 1;
            if (a != cur && m_err < 65535) m_err++;
            m_exp[i] = a + 1;
          end else if (m_err < 65535) begin
            m_err++;
          end
        end
        m_act[i] = 1;
      end
    end
    m_cyc++;
    m_ce = (m_cyc % DIV) == 0;
  endtask

  task automatic step();
    @(posedge Cclk);
    model_edge();
    #1;
    if (FrameDone === 1'b1) fd_count++;
    if (chk_en) begin
      check("chan_done", 24'(ChanDone), 24'(m_done));
      check("frame_done", 24'(FrameDone), 24'(m_fd));
      check("frame_parity", 24'(FrameParity), 24'(m_par));
      check("pixel_ce", 24'(PixelCe), 24'(m_ce));
      if (!$isunknown(m_hdmi)) check("hdmi_data", HDMIdata, m_hdmi);
`ifdef RX_ERR_CNT_EN
      check("err_cnt", 24'(ErrCnt), 24'(m_err));
`endif
    end
  endtask

  task automatic drive_lane(input int ch, input bit vl, input int addr, input logic [11:0] data);
    RecValid[ch]         = vl;
    RecAdd[ch*16 +: 16]  = 16'(addr);
    RecData[ch*12 +: 12] = data;
  endtask

  task automatic write_word(input int ch, input int addr, input logic [11:0] data);
    RecEn[ch] = 1'b1;
    drive_lane(ch, 1'b1, addr, data);
    step();
    RecValid[ch] = 1'b0;
  endtask

  // Restart readout, walk to pixel pix and return HDMIdata two cycles after its strobe.
  task automatic read_pixel(input int pix, input bit coll, input logic [11:0] cdata,
                            output logic [23:0] val);
    int cnt;
    bit found;
    cnt = 0; found = 0; val = '0;
    HMemRead = 0; HVsync = 0;
    step();
    HVsync = 1; HMemRead = 1;
    for (int n = 0; n < (pix + 3) * DIV * 2 + 20 && !found; n++) begin
      if (PixelCe === 1'b1) begin
        if (cnt == pix) begin
          if (coll) begin
            RecEn[pix % 4] = 1'b1;
            drive_lane(pix % 4, 1'b1, pix / 4, cdata);
          end
          step();
          RecValid = '0;
          if (coll) RecEn[pix % 4] = 1'b0;
          step();
          val = HDMIdata;
          found = 1;
        end else begin
          cnt++;
        end
      end
      if (!found) step();
    end
    HMemRead = 0;
    check("read_reached", 24'(found), 24'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    RecEn = '0; RecValid = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] v;
    rst = 1'b1; RecEn = '0; RecValid = '0; RecData = '0; RecAdd = '0;
    RecFrameSync = 0; HVsync = 1; HMemRead = 0;

    tbl[0] = '{2, 5, 12'h123, 24'h1f2f3f};
    tbl[1] = '{0, 0, 12'hfff, 24'hffffff};
    tbl[2] = '{1, 7, 12'h000, 24'h0f0f0f};
    tbl[3] = '{3, 9, 12'ha5c, 24'haf5fcf};
    tbl[4] = '{0, 3, 12'h801, 24'h8f0f1f};

    // reset state
    step();
    chk_en = 1'b1;
    step();
    check("rst_chan_done", 24'(ChanDone), 24'h0);
    check("rst_frame_done", 24'(FrameDone), 24'h0);
    check("rst_parity", 24'(FrameParity), 24'h0);
    check("rst_pixel_ce", 24'(PixelCe), 24'h0);
    check("rst_hdmi", HDMIdata, 24'h0);
    rst = 1'b0;
    step();

    // grey-expand table: write each word, read its pixel back
    for (int k = 0; k < 5; k++) write_word(tbl[k].ch, tbl[k].addr, tbl[k].data);
    RecEn = '0;
    step();
    for (int k = 0; k < 5; k++) begin
      read_pixel(tbl[k].addr * 4 + tbl[k].ch, 1'b0, 12'h0, v);
      check("tbl_hdmi", v, tbl[k].exp);
    end

    // read/write collision on pixel 22: old data returned, new data on the next pass
    read_pixel(22, 1'b1, 12'habc, v);
    check("collision_old", v, 24'h1f2f3f);
    read_pixel(22, 1'b0, 12'h0, v);
    check("collision_new", v, 24'hafbfcf);

    // reset mid-ACTIVE: ch0 up to word 100, then rst
    for (int w = 0; w <= 100; w++) write_word(0, w, 12'(w * 37 + 5));
    fd_count = 0;
    rst = 1'b1; RecEn = '0;
    step();
    rst = 1'b0;
    step();
    check("midrst_chan_done", 24'(ChanDone), 24'h0);
    for (int n = 0; n < 4; n++) step();
    check("midrst_no_frame_done", 24'(fd_count), 24'd0);
    read_pixel(200, 1'b0, 12'h0, v);
    check("midrst_data_kept", v, exp_grey(12'(50 * 37 + 5)));

    // out-of-range write is dropped
    do_reset();
    RecEn = 4'b0100;
    drive_lane(2, 1'b1, DEPTH, 12'h555);
    step();
    RecValid = '0;
    step();
    check("oor_chan_done", 24'(ChanDone), 24'h0);
`ifdef RX_ERR_CNT_EN
    check("oor_err_cnt", 24'(ErrCnt), 24'd1);
`endif
    RecEn = '0;
    step();

`ifdef RX_ERR_CNT_EN
    do_reset();
    write_word(1, 0, 12'h001);
    write_word(1, 1, 12'h002);
    write_word(1, 3, 12'h003);
    step();
    check("seq_err_cnt", 24'(ErrCnt), 24'd1);
    RecEn = '0;
    step();
`endif

    // full frame on all four channels
    fd_count = 0;
    RecFrameSync = 1'b1;
    RecEn = 4'hf;
    for (int w = 0; w < DEPTH; w++) begin
      for (int i = 0; i < 4; i++) drive_lane(i, 1'b1, w, 12'(w * 4 + i));
      step();
    end
    RecValid = '0;
    for (int n = 0; n < 3; n++) step();
    check("frame_chan_done", 24'(ChanDone), 24'hf);
    check("frame_pulse_count", 24'(fd_count), 24'd1);
    check("frame_parity_val", 24'(FrameParity), 24'd1);
    RecEn = '0;
    RecFrameSync = 1'b0;
    step();

    // partial enable: channels 0/1 only, twice
    fd_count = 0;
    RecEn = 4'b0011;
    drive_lane(0, 1'b1, DEPTH - 1, 12'h111);
    drive_lane(1, 1'b1, DEPTH - 1, 12'h222);
    step();
    RecValid = '0;
    for (int n = 0; n < 3; n++) step();
    check("part_chan_done", 24'(ChanDone), 24'h3);
    check("part_pulse1", 24'(fd_count), 24'd1);
    RecEn = '0;
    step();
    RecEn = 4'b0011;
    for (int n = 0; n < 3; n++) step();
    check("part_no_repulse", 24'(fd_count), 24'd1);
    check("part_rearm_done", 24'(ChanDone), 24'h0);
    drive_lane(0, 1'b1, DEPTH - 1, 12'h333);
    drive_lane(1, 1'b1, DEPTH - 1, 12'h444);
    step();
    RecValid = '0;
    for (int n = 0; n < 3; n++) step();
    check("part_pulse2", 24'(fd_count), 24'd2);
    RecEn = '0;
    step();

    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if (n % 64 == 0) RecEn = ($urandom % 2) ? 4'hf : 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        int r, a;
        r = $urandom % 16;
        if (r == 0)      a = DEPTH - 1;
        else if (r == 1) a = DEPTH + $urandom_range(0, 100);
        else             a = $urandom % 64;
        drive_lane(i, 1'($urandom), a, 12'($urandom));
      end
      RecFrameSync = 1'($urandom);
      HVsync       = ($urandom % 100) != 0;
      HMemRead     = 1'($urandom);
      step();
    end
    RecValid = '0; RecEn = '0; HVsync = 1; HMemRead = 0;
    for (int n = 0; n < 4; n++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
